uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning number of payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESCALE_W, default 6, meaning width of the PRESCALE port.
REQ-003 SHALL have port CLK  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous active-low reset.
REQ-005 SHALL have port TX_P_DATA  input  DATA_WIDTH  parallel payload.
REQ-006 SHALL have port TX_Data_valid  input  1  payload-valid request.
REQ-007 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port STOP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port PRESCALE  input  PRESCALE_W  CLK cycles per serial bit.
REQ-011 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port TX_done  output  1  one-cycle frame-complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-015 SHALL accept a frame when TX_Data_valid=1 is sampled while in IDLE; TX_Data_valid is ignored in all other states.
REQ-016 SHALL latch TX_P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE at acceptance; input changes mid-frame have no effect.
REQ-017 SHALL treat a latched PRESCALE of 0 as 1.
REQ-018 SHALL drive TX_OUT=0 (START) starting the cycle after the accepting edge, each bit lasting exactly P cycles (P = effective prescale).
REQ-019 SHALL send DATA_WIDTH data bits LSB first in DATA, using a bit counter of ceil(log2(DATA_WIDTH+1)) bits.
REQ-020 SHALL enter PARITY only when latched PAR_EN=1; parity bit = XOR of data bits (even), or its inverse (odd).
REQ-021 SHALL drive TX_OUT=1 in STOP for 1 or 2 bit periods per latched STOP2.
REQ-022 SHALL hold busy=1 in every non-IDLE state, i.e. for exactly P*(2+DATA_WIDTH+PAR_EN+STOP2) cycles per frame.
REQ-023 SHALL assert TX_done for one cycle, coincident with the last cycle of the final stop bit.
REQ-024 SHALL return to IDLE after the final stop bit; a new frame can be accepted on the first IDLE cycle (TX_Data_valid held high gives back-to-back frames with one idle-high cycle between).
REQ-025 SHALL hold TX_OUT=1 in IDLE.
REQ-026 SHALL use a prescale counter that wraps from P-1 to 0 at each bit boundary; no counter overflow for any PRESCALE value.

Reset
REQ-027 SHALL, when RST=0 at a rising CLK edge, enter IDLE with TX_OUT=1, busy=0, TX_done=0, and all counters and latched registers cleared.
REQ-028 SHALL abort any frame in progress on reset without emitting TX_done; the line returns high on the next cycle.
REQ-029 SHALL ignore TX_Data_valid while RST=0 and on the reset-release edge itself.

Verification
REQ-030 SHALL cover: DATA_WIDTH=8, PRESCALE=1, PAR_EN=0, STOP2=0, data 0xA5 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1; busy high 10 cycles; TX_done on cycle 10.
REQ-031 SHALL cover: data 0xA5, PAR_EN=1, PAR_TYP=0, PRESCALE=4 -> parity bit 0; each bit 4 cycles; frame 44 cycles. PAR_TYP=1 -> parity bit 1.
REQ-032 SHALL cover: DATA_WIDTH=7, STOP2=1, PRESCALE=2, data 0x55 -> 7 data bits 1,0,1,0,1,0,1; stop high 4 cycles; busy 20 cycles.
REQ-033 SHALL cover: TX_Data_valid pulsed and TX_P_DATA/PRESCALE changed mid-frame -> current frame unchanged, no second frame started.
REQ-034 SHALL cover: RST=0 in the middle of DATA -> TX_OUT=1, busy=0 next cycle, no TX_done; the next valid frame is sent correctly.
REQ-035 SHALL cover: PRESCALE=0 with TX_Data_valid held high -> 1-cycle bits, back-to-back frames separated by exactly one idle cycle.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, 5..9 data bits LSB first, optional
// even/odd parity, one or two stop bits, and a per-frame bit-period prescaler.
// Frame settings are captured when a frame is accepted and held until it ends.
module uart_tx_cfg #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] TX_P_DATA,
   input  logic                  TX_Data_valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  TX_done
);

   localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_en_q, par_en_d;
   logic                  stop2_q, stop2_d;
   logic                  armed_q;
   logic                  tx_out_q, tx_out_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_end;
   logic [PRESCALE_W-1:0] pcnt_inc;

   // Next-state, counters, and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      prescale_d = prescale_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_bit_d  = par_bit_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      tx_out_d   = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      bit_end  = (pcnt_q == prescale_q - PRESCALE_W'(1));
      pcnt_inc = bit_end ? '0 : pcnt_q + PRESCALE_W'(1);

      unique case (state_q)
         StIdle: begin
            // armed_q keeps the reset-release edge from accepting a frame
            if (TX_Data_valid && armed_q) begin
               state_d    = StStart;
               shreg_d    = TX_P_DATA;
               par_bit_d  = (^TX_P_DATA) ^ PAR_TYP;
               par_en_d   = PAR_EN;
               stop2_d    = STOP2;
               prescale_d = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
               pcnt_d     = '0;
               bit_cnt_d  = '0;
            end
         end
         StStart: begin
            pcnt_d = pcnt_inc;
            if (bit_end) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            pcnt_d = pcnt_inc;
            if (bit_end) begin
               if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                  state_d   = par_en_q ? StParity : StStop;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         StParity: begin
            pcnt_d = pcnt_inc;
            if (bit_end) begin
               state_d   = StStop;
               bit_cnt_d = '0;
            end
         end
         StStop: begin
            pcnt_d = pcnt_inc;
            if (bit_end) begin
               if (bit_cnt_q == BitCntW'(stop2_q)) begin
                  state_d   = StIdle;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BitCntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are computed from the next state so they can be registered
      // without adding a cycle of latency.
      unique case (state_d)
         StStart:  tx_out_d = 1'b0;
         StData:   tx_out_d = shreg_d[0];
         StParity: tx_out_d = par_bit_d;
         default:  tx_out_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle);
      done_d = (state_d == StStop) && (pcnt_d == prescale_d - PRESCALE_W'(1)) &&
               (bit_cnt_d == BitCntW'(stop2_d));
   end

   // State, counters, latched frame settings and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= StIdle;
         pcnt_q     <= '0;
         prescale_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_bit_q  <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         armed_q    <= 1'b0;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         prescale_q <= prescale_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_bit_q  <= par_bit_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
         armed_q    <= 1'b1;
         tx_out_q   <= tx_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TX_OUT  = tx_out_q;
   assign busy    = busy_q;
   assign TX_done = done_q;

endmodule
